// File: rtl/axi_lite_mem_sequencer.sv
// AXI4-Lite slave front end for a single shared memory/MMIO request port.
// Captures AW, W and AR independently and runs one backend transaction at a time, alternating reads and writes.
module axi_lite_mem_sequencer #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 16,
  parameter int MEM_BYTES          = 16384,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     mem_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     mem_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   mem_wstrb,
  input  logic                              mem_ready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mem_rdata,
  input  logic                              mem_err
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, WR_RESP, RD_RESP} state_t;
  state_t state, state_next;

  logic            aw_full, w_full, ar_full;
  logic            aw_full_next, w_full_next, ar_full_next;
  logic            aw_ready, w_ready, ar_ready;
  logic [AW-1:0]   aw_addr, ar_addr, op_addr;
  logic [DW-1:0]   w_data, rdata;
  logic [DW/8-1:0] w_strb;
  logic            last_wr;
  logic [7:0]      tmo_cnt;
  logic [1:0]      resp;
  logic            aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic            wr_elig, pick_rd, pick_wr;
  logic            aw_oor, ar_oor, tmo_hit, issuing;
  logic            unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign aw_hs = S_AXI_AWVALID & aw_ready;
  assign w_hs  = S_AXI_WVALID & w_ready;
  assign ar_hs = S_AXI_ARVALID & ar_ready;
  assign b_hs  = (state == WR_RESP) & S_AXI_BREADY;
  assign r_hs  = (state == RD_RESP) & S_AXI_RREADY;

  // Capture slots are only released by the response handshake that consumes them.
  assign aw_full_next = (aw_full & ~b_hs) | aw_hs;
  assign w_full_next  = (w_full & ~b_hs) | w_hs;
  assign ar_full_next = (ar_full & ~r_hs) | ar_hs;

  assign wr_elig = aw_full & w_full;
  assign pick_rd = ar_full & (~wr_elig | last_wr);
  assign pick_wr = wr_elig & ~pick_rd;
  assign aw_oor  = 32'(aw_addr) >= 32'(MEM_BYTES);
  assign ar_oor  = 32'(ar_addr) >= 32'(MEM_BYTES);
  assign tmo_hit = tmo_cnt == 8'(TIMEOUT_CYCLES - 1);
  assign issuing = (state == WR_ISSUE) || (state == RD_ISSUE);

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_rd)      state_next = ar_oor ? RD_RESP : RD_ISSUE;
        else if (pick_wr) state_next = aw_oor ? WR_RESP : WR_ISSUE;
      end
      WR_ISSUE: if (mem_ready || tmo_hit) state_next = WR_RESP;
      RD_ISSUE: if (mem_ready || tmo_hit) state_next = RD_RESP;
      WR_RESP:  if (S_AXI_BREADY) state_next = IDLE;
      RD_RESP:  if (S_AXI_RREADY) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      ar_full  <= 1'b0;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      ar_ready <= 1'b0;
      aw_addr  <= '0;
      ar_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      last_wr  <= 1'b1;
      tmo_cnt  <= '0;
      resp     <= '0;
      rdata    <= '0;
    end else begin
      aw_full  <= aw_full_next;
      w_full   <= w_full_next;
      ar_full  <= ar_full_next;
      aw_ready <= ~aw_full_next;
      w_ready  <= ~w_full_next;
      ar_ready <= ~ar_full_next;
      if (aw_hs) aw_addr <= S_AXI_AWADDR;
      if (ar_hs) ar_addr <= S_AXI_ARADDR;
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (b_hs)      last_wr <= 1'b1;
      else if (r_hs) last_wr <= 1'b0;
      tmo_cnt <= (issuing && !mem_ready) ? tmo_cnt + 8'd1 : '0;
      case (state)
        IDLE: begin
          if (state_next == RD_RESP) begin
            resp  <= RESP_SLVERR;
            rdata <= '0;
          end else if (state_next == WR_RESP) begin
            resp <= RESP_SLVERR;
          end
        end
        WR_ISSUE, RD_ISSUE: begin
          if (mem_ready) begin
            resp <= mem_err ? RESP_SLVERR : RESP_OKAY;
            if (state == RD_ISSUE) rdata <= mem_rdata;
          end else if (tmo_hit) begin
            resp <= RESP_SLVERR;
            if (state == RD_ISSUE) rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Capture registers stay frozen while full, so the backend fields are stable for the whole ISSUE state.
  assign op_addr   = (state == WR_ISSUE) ? aw_addr : (state == RD_ISSUE) ? ar_addr : '0;
  assign mem_req   = issuing;
  assign mem_we    = (state == WR_ISSUE);
  assign mem_addr  = {op_addr[AW-1:2], 2'b00};
  assign mem_wdata = (state == WR_ISSUE) ? w_data : '0;
  assign mem_wstrb = (state == WR_ISSUE) ? w_strb : '0;

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_BVALID  = (state == WR_RESP);
  assign S_AXI_RVALID  = (state == RD_RESP);
  assign S_AXI_BRESP   = resp;
  assign S_AXI_RRESP   = resp;
  assign S_AXI_RDATA   = rdata;

endmodule

// File: tb/tb_axi_lite_mem_sequencer.sv
// Scoreboard bench for axi_lite_mem_sequencer: expected responses and backend beats are queued at stimulus time.
module tb_axi_lite_mem_sequencer;

  logic        clk = 1'b0;
  logic        S_AXI_ARESETN = 1'b0;
  logic [15:0] S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [15:0] S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b1;
  logic        mem_err = 1'b0;

  typedef struct packed {logic is_rd; logic [1:0] resp; logic [31:0] data;} rsp_t;
  typedef struct packed {logic we; logic [15:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} be_t;
  rsp_t exp_rsp[$];
  be_t  exp_be[$];

  int checks = 0, failures = 0;
  int req_cycles = 0, valid_cycles = 0, be_count = 0;

  axi_lite_mem_sequencer #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(16),
    .MEM_BYTES(16384),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [15:0] a);
    return {a, 16'h0000} ^ 32'h5A5A_C3C3;
  endfunction

  assign mem_rdata = rd_model(mem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response and backend monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (S_AXI_ARESETN) begin
      rsp_t r;
      be_t  b;
      if (mem_req) req_cycles++;
      if (S_AXI_BVALID || S_AXI_RVALID) begin
        valid_cycles++;
        check("bv_rv_excl", 64'(S_AXI_BVALID & S_AXI_RVALID), 64'(0));
        check("req_in_resp", 64'(mem_req), 64'(0));
      end
      if (mem_req && mem_ready) begin
        be_count++;
        check("be_pending", 64'(exp_be.size() > 0), 64'(1));
        if (exp_be.size() > 0) begin
          b = exp_be.pop_front();
          check("be_we", 64'(mem_we), 64'(b.we));
          check("be_addr", 64'(mem_addr), 64'(b.addr));
          if (b.we) begin
            check("be_wdata", 64'(mem_wdata), 64'(b.wdata));
            check("be_wstrb", 64'(mem_wstrb), 64'(b.wstrb));
          end
        end
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        check("b_pending", 64'(exp_rsp.size() > 0), 64'(1));
        if (exp_rsp.size() > 0) begin
          r = exp_rsp.pop_front();
          check("b_kind", 64'(r.is_rd), 64'(0));
          check("bresp", 64'(S_AXI_BRESP), 64'(r.resp));
        end
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        check("r_pending", 64'(exp_rsp.size() > 0), 64'(1));
        if (exp_rsp.size() > 0) begin
          r = exp_rsp.pop_front();
          check("r_kind", 64'(r.is_rd), 64'(1));
          check("rresp", 64'(S_AXI_RRESP), 64'(r.resp));
          check("rdata", 64'(S_AXI_RDATA), 64'(r.data));
        end
      end
    end
  end

  task automatic exp_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] rsp, input bit be);
    rsp_t r;
    be_t  b;
    r = '{is_rd: 1'b0, resp: rsp, data: 32'h0};
    exp_rsp.push_back(r);
    if (be) begin
      b = '{we: 1'b1, addr: a & 16'hFFFC, wdata: d, wstrb: s};
      exp_be.push_back(b);
    end
  endtask

  task automatic exp_rd(input logic [15:0] a, input logic [1:0] rsp, input logic [31:0] d, input bit be);
    rsp_t r;
    be_t  b;
    r = '{is_rd: 1'b1, resp: rsp, data: d};
    exp_rsp.push_back(r);
    if (be) begin
      b = '{we: 1'b0, addr: a & 16'hFFFC, wdata: 32'h0, wstrb: 4'h0};
      exp_be.push_back(b);
    end
  endtask

  task automatic drive_req(input bit aw, input bit w, input bit ar, input logic [15:0] wa,
                           input logic [31:0] wd, input logic [3:0] ws, input logic [15:0] ra);
    int n;
    bit aw_now, w_now, ar_now;
    n = 0;
    S_AXI_AWADDR = wa; S_AXI_WDATA = wd; S_AXI_WSTRB = ws; S_AXI_ARADDR = ra;
    S_AXI_AWVALID = aw; S_AXI_WVALID = w; S_AXI_ARVALID = ar;
    while ((S_AXI_AWVALID || S_AXI_WVALID || S_AXI_ARVALID) && n < 60) begin
      aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
      w_now  = S_AXI_WVALID && S_AXI_WREADY;
      ar_now = S_AXI_ARVALID && S_AXI_ARREADY;
      tick();
      if (aw_now) S_AXI_AWVALID = 1'b0;
      if (w_now)  S_AXI_WVALID = 1'b0;
      if (ar_now) S_AXI_ARVALID = 1'b0;
      n++;
    end
    check("req_accept", 64'({S_AXI_AWVALID, S_AXI_WVALID, S_AXI_ARVALID}), 64'(0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_rsp.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_rsp", 64'(exp_rsp.size()), 64'(0));
    check("drain_be", 64'(exp_be.size()), 64'(0));
    tick();
  endtask

  task automatic do_reset();
    S_AXI_ARESETN = 1'b0;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    tick();
    check("rst_readies", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(0));
    check("rst_valids", 64'({S_AXI_BVALID, S_AXI_RVALID}), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_rdata", 64'(S_AXI_RDATA), 64'(0));
    S_AXI_ARESETN = 1'b1;
    check("rdy_cycle1", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(0));
    tick();
    check("rdy_cycle2", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(3'b111));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0, r0, v0;
    tick();
    do_reset();

    // Single write, exact latency and B hold until BREADY.
    S_AXI_BREADY = 1'b0;
    exp_wr(16'h0010, 32'hA5A5_1234, 4'hF, 2'b00, 1'b1);
    drive_req(1, 1, 0, 16'h0010, 32'hA5A5_1234, 4'hF, 16'h0);
    check("wr_n1_req", 64'(mem_req), 64'(0));
    tick();
    check("wr_n2_req", 64'({mem_req, mem_we}), 64'(2'b11));
    check("wr_n2_addr", 64'(mem_addr), 64'(16'h0010));
    tick();
    check("wr_n3_bvalid", 64'(S_AXI_BVALID), 64'(1));
    check("wr_n3_bresp", 64'(S_AXI_BRESP), 64'(0));
    tick();
    check("wr_b_hold", 64'(S_AXI_BVALID), 64'(1));
    S_AXI_BREADY = 1'b1;
    tick();
    check("wr_b_drop", 64'(S_AXI_BVALID), 64'(0));
    drain();

    // W three cycles before AW.
    exp_wr(16'h0014, 32'h0BAD_F00D, 4'h3, 2'b00, 1'b1);
    b0 = be_count;
    S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'h3; S_AXI_WVALID = 1'b1;
    check("w_first_rdy", 64'(S_AXI_WREADY), 64'(1));
    tick();
    S_AXI_WVALID = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("wready_low", 64'(S_AXI_WREADY), 64'(0));
      if (c < 3) tick();
    end
    S_AXI_AWADDR = 16'h0014; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    check("w_first_c4_req", 64'(mem_req), 64'(0));
    tick();
    check("w_first_c5_req", 64'(mem_req), 64'(1));
    drain();
    check("w_first_be_count", 64'(be_count - b0), 64'(1));

    // Round-robin ties: read wins from reset and after a write; write wins after a read.
    do_reset();
    exp_rd(16'h0020, 2'b00, rd_model(16'h0020), 1'b1);
    exp_wr(16'h0030, 32'h1111_2222, 4'hF, 2'b00, 1'b1);
    drive_req(1, 1, 1, 16'h0030, 32'h1111_2222, 4'hF, 16'h0020);
    drain();
    exp_rd(16'h0024, 2'b00, rd_model(16'h0024), 1'b1);
    exp_wr(16'h0034, 32'h3333_4444, 4'hC, 2'b00, 1'b1);
    drive_req(1, 1, 1, 16'h0034, 32'h3333_4444, 4'hC, 16'h0024);
    drain();
    exp_rd(16'h0028, 2'b00, rd_model(16'h0028), 1'b1);
    drive_req(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0028);
    drain();
    exp_wr(16'h0038, 32'h5555_6666, 4'h1, 2'b00, 1'b1);
    exp_rd(16'h002C, 2'b00, rd_model(16'h002C), 1'b1);
    drive_req(1, 1, 1, 16'h0038, 32'h5555_6666, 4'h1, 16'h002C);
    drain();

    // Address decode boundary.
    r0 = req_cycles;
    exp_rd(16'h4000, 2'b10, 32'h0, 1'b0);
    drive_req(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h4000);
    drain();
    exp_wr(16'hFFFC, 32'hDEAD_BEEF, 4'hF, 2'b10, 1'b0);
    drive_req(1, 1, 0, 16'hFFFC, 32'hDEAD_BEEF, 4'hF, 16'h0);
    drain();
    check("oor_no_req", 64'(req_cycles - r0), 64'(0));
    exp_rd(16'h3FFE, 2'b00, rd_model(16'h3FFC), 1'b1);
    drive_req(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h3FFE);
    drain();

    // Backend error flag.
    mem_err = 1'b1;
    exp_rd(16'h0060, 2'b10, rd_model(16'h0060), 1'b1);
    drive_req(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0060);
    drain();
    mem_err = 1'b0;

    // Timeouts, then a normal write.
    mem_ready = 1'b0;
    r0 = req_cycles;
    exp_wr(16'h0040, 32'h7777_8888, 4'hF, 2'b10, 1'b0);
    drive_req(1, 1, 0, 16'h0040, 32'h7777_8888, 4'hF, 16'h0);
    drain();
    check("tmo_wr_req_cycles", 64'(req_cycles - r0), 64'(4));
    r0 = req_cycles;
    exp_rd(16'h0044, 2'b10, 32'h0, 1'b0);
    drive_req(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0044);
    drain();
    check("tmo_rd_req_cycles", 64'(req_cycles - r0), 64'(4));
    mem_ready = 1'b1;
    exp_wr(16'h0048, 32'h9999_AAAA, 4'hF, 2'b00, 1'b1);
    drive_req(1, 1, 0, 16'h0048, 32'h9999_AAAA, 4'hF, 16'h0);
    drain();

    // Reset while a read is in flight.
    mem_ready = 1'b0;
    drive_req(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0050);
    tick();
    check("mid_req_high", 64'(mem_req), 64'(1));
    do_reset();
    v0 = valid_cycles;
    r0 = req_cycles;
    repeat (10) tick();
    check("no_stale_valid", 64'(valid_cycles - v0), 64'(0));
    check("no_stale_req", 64'(req_cycles - r0), 64'(0));
    mem_ready = 1'b1;
    exp_rd(16'h0054, 2'b00, rd_model(16'h0054), 1'b1);
    drive_req(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0054);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_sequencer.md
Name: axi_lite_mem_sequencer

Overview:
AXI4-Lite slave controller that sits behind the FPGA top-level AXI4-Lite port and lets the host access the core's memory/MMIO through a single shared request/ready port. It captures write-address, write-data and read-address independently, arbitrates reads against writes round-robin, and issues exactly one backend transaction at a time. It generates the B and R responses, including SLVERR for out-of-range addresses and backend timeouts.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data and backend data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 16, AXI byte-address width.
MEM_BYTES, 16384, size of the backend window; addresses >= MEM_BYTES decode as out of range.
TIMEOUT_CYCLES, 255, maximum number of cycles to wait for mem_ready before abandoning a request; range 1..255.

Ports:
S_AXI_ACLK  in  1  sole clock
S_AXI_ARESETN  in  1  synchronous, active-low reset
S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR/3/1  write-address channel; AWPROT is ignored
S_AXI_AWREADY  out  1
S_AXI_WDATA/WSTRB/WVALID  in  32/4/1  write-data channel
S_AXI_WREADY  out  1
S_AXI_BRESP  out  2;  S_AXI_BVALID  out  1;  S_AXI_BREADY  in  1
S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR/3/1  read-address channel; ARPROT is ignored
S_AXI_ARREADY  out  1
S_AXI_RDATA  out  32;  S_AXI_RRESP  out  2;  S_AXI_RVALID  out  1;  S_AXI_RREADY  in  1
mem_req  out  1  backend request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR  byte address with bits [1:0] forced to 0
mem_wdata  out  32;  mem_wstrb  out  4
mem_ready  in  1  backend completion; sampled only while mem_req = 1
mem_rdata  in  32  valid in the cycle mem_ready = 1
mem_err  in  1  backend error; valid in the cycle mem_ready = 1

Behaviour:
- Reset (S_AXI_ARESETN = 0 at a clock edge):
  - All holding flags cleared; state = IDLE.
  - Every output is 0, including all readies, BVALID, RVALID, mem_req and RDATA.
  - Priority flag last_wr = 1, so a read wins the first tie.
  - A reset arriving mid-operation abandons any in-flight backend request and pending response; no response is ever issued for it.
- Capture registers:
  - aw_full, w_full, ar_full each hold one entry.
  - AWREADY = !aw_full, WREADY = !w_full, ARREADY = !ar_full. All three are registered and are 0 in the first cycle after reset release.
  - A handshake (VALID & READY) loads the corresponding register. AW and W may arrive in either order or in the same cycle.
- States: IDLE, WR_ISSUE, RD_ISSUE, WR_RESP, RD_RESP.
- IDLE:
  - A write is eligible when aw_full & w_full; a read is eligible when ar_full.
  - If both are eligible: go to RD_ISSUE when last_wr = 1, otherwise WR_ISSUE. A single eligible request is taken directly.
  - If the captured address is >= MEM_BYTES, skip ISSUE and go straight to RESP with resp = 2'b10 (SLVERR). In that case RDATA = 0 and no mem_req is issued.
- ISSUE:
  - mem_req = 1, with mem_we, mem_addr, mem_wdata and mem_wstrb held stable until completion.
  - The timeout counter is cleared on entry and increments every cycle without mem_ready.
  - On mem_ready: resp = mem_err ? 2'b10 : 2'b00; for a read, RDATA <= mem_rdata. Go to RESP.
  - If the counter reaches TIMEOUT_CYCLES: drop mem_req, resp = 2'b10, RDATA = 0, go to RESP.
- RESP:
  - BVALID or RVALID asserted with BRESP/RRESP set; the response holds until the matching READY.
  - On that handshake: clear the consumed capture flags (aw+w, or ar), set last_wr (1 after a write, 0 after a read), return to IDLE.
  - mem_req = 0 throughout RESP.
- Latency, zero-wait backend:
  - Final AW/W (or AR) handshake in cycle N.
  - mem_req high in cycle N+2.
  - BVALID/RVALID high in cycle N+3.
  - Minimum 4 cycles per transaction at a sustained rate.
- A new AW, W or AR may be captured while a different transaction is in ISSUE or RESP; the capture registers are only freed in RESP.
- BVALID and RVALID are never asserted together.

Test Plan:
- Single write: AW=0x0010, W=0xA5A5_1234, WSTRB=0xF, mem_ready tied high -> mem_req in cycle N+2 with mem_addr=0x0010, mem_we=1; BVALID in cycle N+3 with BRESP=00; BVALID drops after BREADY.
- W before AW: W at cycle 0, AW at cycle 3 -> WREADY=0 in cycles 1-3; mem_req in cycle 5; exactly one backend write.
- Simultaneous eligible read and write from reset: AR=0x0020 and AW/W=0x0030 held together -> read issued first (RVALID, RDATA=mem_rdata), then the write. The next tie goes to the read again only after a write has completed.
- Out of range: ARADDR=0x4000 with MEM_BYTES=16384 -> no mem_req; RVALID with RRESP=10 and RDATA=0.
- Timeout: mem_ready held 0, TIMEOUT_CYCLES=4 -> mem_req high for exactly 4 cycles, then BRESP=10; a later write with mem_ready=1 completes normally with OKAY.
- Reset mid-ISSUE: assert ARESETN=0 while mem_req=1 -> next cycle mem_req=0, all VALIDs 0, all readies 0; after release, readies rise in cycle 2 and no stale response appears.
